// File: rtl/inst_queue_decoder_if.sv
// ----------------------------------------------------------------------------
// inst_queue_decoder_if
//   Bundles the fetch-side push signals, the dispatch-side control inputs and
//   the decoded instruction bundle of the instruction queue/decoder.
//   Modports:
//     slave  : the queue/decoder (consumes fetch + control, drives iq_full/dec_*)
//     master : the environment (fetch unit, ROB/dispatch stall and flush)
//   Signals:
//     flush, stall               control from ROB / dispatch
//     if_ready, if_inst, if_pc,  instruction pushed by fetch
//     if_jump_pred
//     iq_full                    queue cannot accept a push
//     dec_ready, dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc,
//     dec_jump_pred              registered decoded bundle
// ----------------------------------------------------------------------------
interface inst_queue_decoder_if #(
  parameter int XLEN            = 32,
  parameter int INST_TYPE_WIDTH = 6,
  parameter int REG_CNT_WIDTH   = 5
);
  logic                       flush;
  logic                       stall;
  logic                       if_ready;
  logic [31:0]                if_inst;
  logic [XLEN-1:0]            if_pc;
  logic                       if_jump_pred;
  logic                       iq_full;
  logic                       dec_ready;
  logic [INST_TYPE_WIDTH-1:0] dec_op;
  logic                       dec_jump_pred;
  logic [REG_CNT_WIDTH-1:0]   dec_rd;
  logic [REG_CNT_WIDTH-1:0]   dec_rs1;
  logic [REG_CNT_WIDTH-1:0]   dec_rs2;
  logic [XLEN-1:0]            dec_imm;
  logic [XLEN-1:0]            dec_pc;

  modport slave (
    input  flush, stall, if_ready, if_inst, if_pc, if_jump_pred,
    output iq_full, dec_ready, dec_op, dec_jump_pred, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_pc
  );

  modport master (
    output flush, stall, if_ready, if_inst, if_pc, if_jump_pred,
    input  iq_full, dec_ready, dec_op, dec_jump_pred, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_pc
  );
endinterface

// File: rtl/inst_queue_decoder.sv
// ----------------------------------------------------------------------------
// inst_queue_decoder
//   Circular FIFO of fetched RV32I instructions (2**IQ_SIZE_WIDTH entries)
//   followed by a registered decode stage. The head entry is decoded
//   combinationally and captured into the dec_* bundle whenever the bundle
//   is empty or being consumed (dec_ready && !stall).
//   Ports:
//     clk  in  clock, all state on posedge
//     rst  in  synchronous active-high reset
//     bus  slave modport of inst_queue_decoder_if (fetch push, flush/stall,
//          iq_full and the dec_* bundle)
//   Instruction type codes (dec_op):
//     0 LUI  1 AUIPC 2 JAL  3 JALR 4 BEQ  5 BNE  6 BLT  7 BGE  8 BLTU 9 BGEU
//     10 LB 11 LH 12 LW 13 LBU 14 LHU 15 SB 16 SH 17 SW 18 ADDI 19 SLTI
//     20 SLTIU 21 XORI 22 ORI 23 ANDI 24 SLLI 25 SRLI 26 SRAI 27 ADD 28 SUB
//     29 SLL 30 SLT 31 SLTU 32 XOR 33 SRL 34 SRA 35 OR 36 AND 37 HALT
//   A HALT bundle carries rd/rs1/rs2/imm = 0.
// ----------------------------------------------------------------------------
module inst_queue_decoder #(
  parameter int IQ_SIZE_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  inst_queue_decoder_if.slave bus
);
  localparam int XLEN    = 32;
  localparam int IQ_SIZE = 2 ** IQ_SIZE_WIDTH;
  localparam int CW      = IQ_SIZE_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(IQ_SIZE);

  localparam logic [5:0] OP_LUI  = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL  = 6'd2,  OP_JALR = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4,  OP_BNE   = 6'd5,  OP_BLT  = 6'd6,  OP_BGE  = 6'd7;
  localparam logic [5:0] OP_BLTU = 6'd8,  OP_BGEU  = 6'd9,  OP_LB   = 6'd10, OP_LH   = 6'd11;
  localparam logic [5:0] OP_LW   = 6'd12, OP_LBU   = 6'd13, OP_LHU  = 6'd14, OP_SB   = 6'd15;
  localparam logic [5:0] OP_SH   = 6'd16, OP_SW    = 6'd17, OP_ADDI = 6'd18, OP_SLTI = 6'd19;
  localparam logic [5:0] OP_SLTIU = 6'd20, OP_XORI = 6'd21, OP_ORI  = 6'd22, OP_ANDI = 6'd23;
  localparam logic [5:0] OP_SLLI = 6'd24, OP_SRLI  = 6'd25, OP_SRAI = 6'd26, OP_ADD  = 6'd27;
  localparam logic [5:0] OP_SUB  = 6'd28, OP_SLL   = 6'd29, OP_SLT  = 6'd30, OP_SLTU = 6'd31;
  localparam logic [5:0] OP_XOR  = 6'd32, OP_SRL   = 6'd33, OP_SRA  = 6'd34, OP_OR   = 6'd35;
  localparam logic [5:0] OP_AND  = 6'd36, OP_HALT  = 6'd37;

  // Queue storage (data only, never reset) and pointers
  logic [31:0]              inst_mem_q [IQ_SIZE];
  logic [XLEN-1:0]          pc_mem_q   [IQ_SIZE];
  logic [IQ_SIZE-1:0]       pred_mem_q;
  logic [IQ_SIZE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     dec_ready_q, dec_ready_d;

  // Registered output bundle
  logic [5:0]      dec_op_q;
  logic [4:0]      dec_rd_q, dec_rs1_q, dec_rs2_q;
  logic [XLEN-1:0] dec_imm_q, dec_pc_q;
  logic            dec_pred_q;

  // Combinational decode of the head entry
  logic [5:0]      dec_op_d;
  logic [4:0]      dec_rd_d, dec_rs1_d, dec_rs2_d;
  logic [XLEN-1:0] dec_imm_d;

  logic full, push, load, drain;

  assign full  = (count_q == FULL_CNT);
  assign push  = bus.if_ready && !full;
  // The output register refills whenever it is empty or being handed off.
  assign load  = (!dec_ready_q || !bus.stall) && (count_q != '0);
  assign drain = dec_ready_q && !bus.stall && (count_q == '0);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    dec_ready_d = dec_ready_q;
    if (bus.flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      dec_ready_d = 1'b0;
    end else begin
      if (push) tail_d = tail_q + IQ_SIZE_WIDTH'(1);
      if (load) begin
        head_d      = head_q + IQ_SIZE_WIDTH'(1);
        dec_ready_d = 1'b1;
      end else if (drain) begin
        dec_ready_d = 1'b0;
      end
      case ({push, load})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dec_ready_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dec_ready_q <= dec_ready_d;
    end
  end

  // A write during flush lands at a slot that the pointer reset abandons.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[tail_q] <= bus.if_inst;
      pc_mem_q[tail_q]   <= bus.if_pc;
      pred_mem_q[tail_q] <= bus.if_jump_pred;
    end
  end

  logic [31:0]     hinst;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign hinst  = inst_mem_q[head_q];
  assign opc    = hinst[6:0];
  assign f3     = hinst[14:12];
  assign f7     = hinst[31:25];
  assign imm_i  = {{20{hinst[31]}}, hinst[31:20]};
  assign imm_s  = {{20{hinst[31]}}, hinst[31:25], hinst[11:7]};
  assign imm_b  = {{19{hinst[31]}}, hinst[31], hinst[7], hinst[30:25], hinst[11:8], 1'b0};
  assign imm_u  = {hinst[31:12], 12'b0};
  assign imm_j  = {{11{hinst[31]}}, hinst[31], hinst[19:12], hinst[20], hinst[30:21], 1'b0};
  assign imm_sh = {27'b0, hinst[24:20]};

  always_comb begin
    dec_op_d  = OP_HALT;
    dec_rd_d  = hinst[11:7];
    dec_rs1_d = hinst[19:15];
    dec_rs2_d = hinst[24:20];
    dec_imm_d = '0;
    case (opc)
      7'b0110111: begin dec_op_d = OP_LUI;   dec_rs1_d = '0; dec_rs2_d = '0; dec_imm_d = imm_u; end
      7'b0010111: begin dec_op_d = OP_AUIPC; dec_rs1_d = '0; dec_rs2_d = '0; dec_imm_d = imm_u; end
      7'b1101111: begin dec_op_d = OP_JAL;   dec_rs1_d = '0; dec_rs2_d = '0; dec_imm_d = imm_j; end
      7'b1100111: begin
        if (f3 == 3'b000) dec_op_d = OP_JALR;
        dec_rs2_d = '0;
        dec_imm_d = imm_i;
      end
      7'b1100011: begin
        case (f3)
          3'b000:  dec_op_d = OP_BEQ;
          3'b001:  dec_op_d = OP_BNE;
          3'b100:  dec_op_d = OP_BLT;
          3'b101:  dec_op_d = OP_BGE;
          3'b110:  dec_op_d = OP_BLTU;
          3'b111:  dec_op_d = OP_BGEU;
          default: dec_op_d = OP_HALT;
        endcase
        dec_rd_d  = '0;
        dec_imm_d = imm_b;
      end
      7'b0000011: begin
        case (f3)
          3'b000:  dec_op_d = OP_LB;
          3'b001:  dec_op_d = OP_LH;
          3'b010:  dec_op_d = OP_LW;
          3'b100:  dec_op_d = OP_LBU;
          3'b101:  dec_op_d = OP_LHU;
          default: dec_op_d = OP_HALT;
        endcase
        dec_rs2_d = '0;
        dec_imm_d = imm_i;
      end
      7'b0100011: begin
        case (f3)
          3'b000:  dec_op_d = OP_SB;
          3'b001:  dec_op_d = OP_SH;
          3'b010:  dec_op_d = OP_SW;
          default: dec_op_d = OP_HALT;
        endcase
        dec_rd_d  = '0;
        dec_imm_d = imm_s;
      end
      7'b0010011: begin
        dec_rs2_d = '0;
        dec_imm_d = imm_i;
        case (f3)
          3'b000:  dec_op_d = OP_ADDI;
          3'b010:  dec_op_d = OP_SLTI;
          3'b011:  dec_op_d = OP_SLTIU;
          3'b100:  dec_op_d = OP_XORI;
          3'b110:  dec_op_d = OP_ORI;
          3'b111:  dec_op_d = OP_ANDI;
          // Shift-immediates carry only a 5-bit shamt; funct7 must be legal.
          3'b001: begin
            dec_imm_d = imm_sh;
            if (f7 == 7'b0000000) dec_op_d = OP_SLLI;
          end
          default: begin
            dec_imm_d = imm_sh;
            if (f7 == 7'b0000000)      dec_op_d = OP_SRLI;
            else if (f7 == 7'b0100000) dec_op_d = OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op_d = OP_ADD;
            3'b001:  dec_op_d = OP_SLL;
            3'b010:  dec_op_d = OP_SLT;
            3'b011:  dec_op_d = OP_SLTU;
            3'b100:  dec_op_d = OP_XOR;
            3'b101:  dec_op_d = OP_SRL;
            3'b110:  dec_op_d = OP_OR;
            default: dec_op_d = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec_op_d = OP_SUB;
          else if (f3 == 3'b101) dec_op_d = OP_SRA;
        end
      end
      default: dec_op_d = OP_HALT;
    endcase
    // addi x10,x0,255 is the simulation halt marker, not a real ADDI.
    if (hinst == 32'h0ff00513) dec_op_d = OP_HALT;
    if (dec_op_d == OP_HALT) begin
      dec_rd_d  = '0;
      dec_rs1_d = '0;
      dec_rs2_d = '0;
      dec_imm_d = '0;
    end
  end

  // Decode stage -> output bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_op_q   <= '0;
      dec_rd_q   <= '0;
      dec_rs1_q  <= '0;
      dec_rs2_q  <= '0;
      dec_imm_q  <= '0;
      dec_pc_q   <= '0;
      dec_pred_q <= 1'b0;
    end else if (!bus.flush && load) begin
      dec_op_q   <= dec_op_d;
      dec_rd_q   <= dec_rd_d;
      dec_rs1_q  <= dec_rs1_d;
      dec_rs2_q  <= dec_rs2_d;
      dec_imm_q  <= dec_imm_d;
      dec_pc_q   <= pc_mem_q[head_q];
      dec_pred_q <= pred_mem_q[head_q];
    end
  end

  assign bus.iq_full       = full;
  assign bus.dec_ready     = dec_ready_q;
  assign bus.dec_op        = dec_op_q;
  assign bus.dec_rd        = dec_rd_q;
  assign bus.dec_rs1       = dec_rs1_q;
  assign bus.dec_rs2       = dec_rs2_q;
  assign bus.dec_imm       = dec_imm_q;
  assign bus.dec_pc        = dec_pc_q;
  assign bus.dec_jump_pred = dec_pred_q;
endmodule
